// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: ALU/divider select encodings, XLEN and
// the divider FSM state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIVSEL_DIV  = 2'd0;
  localparam logic [1:0] DIVSEL_DIVU = 2'd1;
  localparam logic [1:0] DIVSEL_REM  = 2'd2;
  localparam logic [1:0] DIVSEL_REMU = 2'd3;

  localparam logic [3:0] ALUSEL_ADD  = 4'd0;
  localparam logic [3:0] ALUSEL_SUB  = 4'd1;
  localparam logic [3:0] ALUSEL_SLL  = 4'd2;
  localparam logic [3:0] ALUSEL_SLT  = 4'd3;
  localparam logic [3:0] ALUSEL_SLTU = 4'd4;
  localparam logic [3:0] ALUSEL_XOR  = 4'd5;
  localparam logic [3:0] ALUSEL_SRL  = 4'd6;
  localparam logic [3:0] ALUSEL_SRA  = 4'd7;
  localparam logic [3:0] ALUSEL_OR   = 4'd8;
  localparam logic [3:0] ALUSEL_AND  = 4'd9;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic is_signed_op(input logic [1:0] sel);
    return (sel == DIVSEL_DIV) || (sel == DIVSEL_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] sel);
    return (sel == DIVSEL_REM) || (sel == DIVSEL_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  // Compare at W+1 bits so a divisor with its MSB set is handled correctly.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted[W-1:0] - dvs;
    q_bit   = (shifted >= {1'b0, dvs});
    rem_out = q_bit ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional `DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip the iteration.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      DivSel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv32_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd, dvs, rem, quot, a_raw;
  logic [1:0]       op;
  logic             sign_q, sign_r, div0, ovf;

  logic             s_op, in_div0, in_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN-1:0]  rem_next, quot_next;
  logic             q_bit;

  // Special cases override the iterated values so both builds agree bit for bit.
  function automatic logic [XLEN-1:0] fix_result(
    input logic rem_op, input logic sq, input logic sr, input logic z, input logic o,
    input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] res;
    if (z)           res = rem_op ? a : {XLEN{1'b1}};
    else if (o)      res = rem_op ? '0 : INT_MIN;
    else if (rem_op) res = sr ? -r : r;
    else             res = sq ? -q : q;
    return res;
  endfunction

  always_comb begin
    s_op    = is_signed_op(DivSel);
    a_mag   = (s_op && A[XLEN-1]) ? -A : A;
    b_mag   = (s_op && B[XLEN-1]) ? -B : B;
    in_div0 = (B == '0);
    in_ovf  = s_op && (A == INT_MIN) && (B == {XLEN{1'b1}});
  end

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign quot_next = {quot[XLEN-2:0], q_bit};
  assign busy      = (state == DIV_RUN);
  assign done      = (state == DIV_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quot   <= '0;
      a_raw  <= '0;
      op     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            op     <= DivSel;
            sign_q <= s_op && (A[XLEN-1] ^ B[XLEN-1]);
            sign_r <= s_op && A[XLEN-1];
            div0   <= in_div0;
            ovf    <= in_ovf;
            a_raw  <= A;
            dvd    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            quot   <= '0;
            cnt    <= '0;
`ifdef DIV_FAST_PATH_EN
            if (in_div0 || in_ovf) begin
              result <= fix_result(is_rem_op(DivSel), 1'b0, 1'b0, in_div0, in_ovf,
                                   '0, '0, A);
              state  <= DIV_DONE;
            end else begin
              state  <= DIV_RUN;
            end
`else
            state  <= DIV_RUN;
`endif
          end
        end
        DIV_RUN: begin
          rem  <= rem_next;
          quot <= quot_next;
          dvd  <= {dvd[XLEN-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
          // Result is registered on the final step so it is valid while done is high.
          if (cnt == LAST_STEP) begin
            result <= fix_result(is_rem_op(op), sign_q, sign_r, div0, ovf,
                                 quot_next, rem_next, a_raw);
            state  <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed + scoreboard bench for div_unit; latency expectations follow DIV_FAST_PATH_EN.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  DivSel = '0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

`ifdef DIV_FAST_PATH_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = 33;
`endif
  localparam int LAT = 33;

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .DivSel (DivSel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation, wait for done within a budget, check latency, result and pulse.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sel, input logic [31:0] exp, input int lat,
                       input bit repulse);
    int n;
    logic [31:0] got;
    @(negedge clk);
    A = a; B = b; DivSel = sel; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    if (lat > 1) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (!done && n < 200) begin
      if (repulse) begin
        A = $urandom; B = $urandom; DivSel = 2'($urandom_range(0, 3));
        start = (n == 5 || n == 6 || n == 20) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat));
    got = result;
    check(tag, got, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    do_op("div_100_7",   32'd100,       32'd7,         2'd0, 32'd14,        LAT, 1'b0);
    do_op("rem_100_7",   32'd100,       32'd7,         2'd2, 32'd2,         LAT, 1'b0);
    do_op("div_m100_7",  32'hFFFFFF9C,  32'd7,         2'd0, 32'hFFFFFFF2,  LAT, 1'b0);
    do_op("rem_m100_7",  32'hFFFFFF9C,  32'd7,         2'd2, 32'hFFFFFFFE,  LAT, 1'b0);
    do_op("rem_100_m7",  32'd100,       32'hFFFFFFF9,  2'd2, 32'd2,         LAT, 1'b0);
    do_op("divu_max_2",  32'hFFFFFFFF,  32'd2,         2'd1, 32'h7FFFFFFF,  LAT, 1'b0);
    do_op("remu_max_2",  32'hFFFFFFFF,  32'd2,         2'd3, 32'd1,         LAT, 1'b0);
    do_op("div_m1_2",    32'hFFFFFFFF,  32'd2,         2'd0, 32'd0,         LAT, 1'b0);

    do_op("div_by0",     32'h1234,      32'd0,         2'd0, 32'hFFFFFFFF,  LAT_SP, 1'b0);
    do_op("divu_by0",    32'h1234,      32'd0,         2'd1, 32'hFFFFFFFF,  LAT_SP, 1'b0);
    do_op("rem_by0",     32'h1234,      32'd0,         2'd2, 32'h1234,      LAT_SP, 1'b0);
    do_op("remu_by0",    32'h1234,      32'd0,         2'd3, 32'h1234,      LAT_SP, 1'b0);
    do_op("div_ovf",     32'h80000000,  32'hFFFFFFFF,  2'd0, 32'h80000000,  LAT_SP, 1'b0);
    do_op("rem_ovf",     32'h80000000,  32'hFFFFFFFF,  2'd2, 32'd0,         LAT_SP, 1'b0);
    do_op("divu_big_dvs", 32'hF0000000, 32'h80000001,  2'd1, 32'd1,         LAT, 1'b0);

    do_op("div_repulse", 32'd1000,      32'd3,         2'd0, 32'd333,       LAT, 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 65535));
      if (i[0]) do_op("remu_rand", ra, rb, 2'd3, ra % rb, LAT, 1'b0);
      else      do_op("divu_rand", ra, rb, 2'd1, ra / rb, LAT, 1'b0);
    end

    // Abort mid-run: asynchronous reset must clear busy/done/result at once.
    @(negedge clk);
    A = 32'd1000; B = 32'd3; DivSel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("divu_after_rst", 32'h12345678, 32'h100, 2'd1, 32'h00123456, LAT, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
